// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave sram-like bus arbiter.
// Zero added latency; in-order owner FIFO routes each data_ok back to its issuer.
module sram_like_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_e;

    lock_e            lock_q, lock_d;
    logic             last_q, last_d;
    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic win_data;
    logic sel_data;
    logic win_req;
    logic full;
    logic accept;
    logic pop;
    logic head;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_q  <= LOCK_NONE;
            last_q  <= 1'b0;
            fifo_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            lock_q  <= lock_d;
            last_q  <= last_d;
            fifo_q  <= fifo_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Winner selection: lock overrides round-robin
    always_comb begin
        win_data = 1'b0;
        unique case (lock_q)
            LOCK_INST: win_data = 1'b0;
            LOCK_DATA: win_data = 1'b1;
            default:   win_data = data_req & (~inst_req | ~last_q);
        endcase
    end

    assign sel_data = win_data & rst;
    assign win_req  = sel_data ? data_req : inst_req;
    assign full     = (count_q == CW'(DEPTH));
    assign accept   = mem_req & mem_addr_ok;
    assign pop      = mem_data_ok & (count_q != '0) & rst;
    assign head     = fifo_q[rptr_q];

    // Slave port; full blocks without looking at mem_data_ok
    assign mem_req   = win_req & ~full & rst;
    assign mem_wr    = sel_data ? data_wr    : inst_wr;
    assign mem_size  = sel_data ? data_size  : inst_size;
    assign mem_addr  = sel_data ? data_addr  : inst_addr;
    assign mem_wdata = sel_data ? data_wdata : inst_wdata;

    assign inst_addr_ok = accept & ~sel_data;
    assign data_addr_ok = accept &  sel_data;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop &  head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Lock next-state
    always_comb begin
        lock_d = lock_q;
        unique case (1'b1)
            accept:
                lock_d = LOCK_NONE;
            mem_req & ~mem_addr_ok:
                lock_d = sel_data ? LOCK_DATA : LOCK_INST;
            (lock_q == LOCK_INST) & ~inst_req,
            (lock_q == LOCK_DATA) & ~data_req:
                lock_d = LOCK_NONE;
            default: ;
        endcase
    end

    // Owner FIFO and round-robin history
    always_comb begin
        fifo_d = fifo_q;
        if (accept) begin
            fifo_d[wptr_q] = sel_data;
        end
        wptr_d  = wptr_q + PW'(accept);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(accept) - CW'(pop);
        last_d  = accept ? sel_data : last_q;
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master to one-slave arbiter for the core's sram-like bus. It merges the `mips` instruction port (`inst_*`) and data port (`data_*`) onto a single sram-like memory port (`mem_*`), for the unified memory/cache bridge. It adds zero cycles of latency. It tracks up to `DEPTH` outstanding requests in an in-order owner FIFO, so each `data_ok` and its `rdata` return to the master that issued the request.

## Interface
- `DEPTH`, 4, max outstanding accepted-but-unanswered requests; power of two, 2..8
- `clk` input 1 — clock, all state on rising edge
- `rst` input 1 — synchronous, active-low reset
- `inst_req`, `inst_wr` input 1 — instruction master request, write flag
- `inst_size` input 2; `inst_addr`, `inst_wdata` input 32 — instruction master request fields
- `inst_rdata` output 32; `inst_addr_ok`, `inst_data_ok` output 1 — instruction master responses
- `data_req`, `data_wr` input 1; `data_size` input 2; `data_addr`, `data_wdata` input 32 — data master request fields
- `data_rdata` output 32; `data_addr_ok`, `data_data_ok` output 1 — data master responses
- `mem_req`, `mem_wr` output 1; `mem_size` output 2; `mem_addr`, `mem_wdata` output 32 — to the slave
- `mem_rdata` input 32; `mem_addr_ok`, `mem_data_ok` input 1 — from the slave

## Operation
- **Protocol (sram-like):**
  - A master holds `req` and its fields stable until `addr_ok`.
  - The slave answers `data_ok` in acceptance order, at least 1 cycle after the matching `addr_ok`.
- **State:**
  - owner FIFO, `DEPTH` x 1 bit (0 = inst, 1 = data), with `count` 0..`DEPTH`
  - `lock` ∈ {NONE, INST, DATA}
  - `last`, the last accepted owner
- **Selection when `lock` = NONE:**
  - If only one master requests, that master wins.
  - If both request, the master ≠ `last` wins (round-robin).
- **Selection when `lock` ≠ NONE:** the locked owner wins unconditionally.
- **Slave port:**
  - `mem_req` = winner's `req` && `count` != `DEPTH` && `rst`.
  - `mem_wr/size/addr/wdata` = winner's fields. When there is no winner, they take the inst fields.
- **Lock:**
  - Set to the winner when `mem_req` && !`mem_addr_ok`.
  - Cleared on `mem_req` && `mem_addr_ok`.
  - Also cleared if the locked master drops `req` (defensive against a protocol violation).
  - A blocked-by-full cycle does not set `lock`.
- **Accept** (`mem_req` && `mem_addr_ok`):
  - Push the winner ID and set `last` to the winner.
  - Assert only the winner's `addr_ok`, combinationally from `mem_addr_ok`.
- **Return** (`mem_data_ok` && `count` > 0):
  - Pop the head.
  - Assert `inst_data_ok` or `data_data_ok` according to the head ID.
- **`rdata`:** `mem_rdata` drives both `inst_rdata` and `data_rdata`. Only the matching `data_ok` qualifies it.
- **`mem_data_ok` with `count` = 0:** ignored; no `data_ok`, `count` stays 0. This holds even if an accept happens in the same cycle.
- **Push and pop in one cycle:** `count` unchanged; pointers both advance.
- **Full (`count` = `DEPTH`):**
  - `mem_req` = 0, even if a pop occurs in the same cycle. This avoids a combinational path from `mem_data_ok` to `mem_req`.
  - Requests resume the next cycle.
- **Pointer wrap:** read/write pointers are log2(`DEPTH`) bits and wrap naturally; `count` is a separate (log2(`DEPTH`)+1)-bit counter.

## Timing
- **Reset:**
  - While `rst` = 0: `count` = 0, pointers = 0, `lock` = NONE, `last` = inst (so data wins the first tie).
  - While `rst` = 0: `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` are forced 0.
  - While `rst` = 0: `mem_*` request fields follow the inst fields; `rdata` outputs follow `mem_rdata`.
- **Reset mid-operation:**
  - All outstanding FIFO entries are discarded.
  - `mem_data_ok` arriving later for pre-reset requests is dropped (empty rule).
- **Added latency:** 0 cycles request→`mem_req`, 0 cycles `mem_addr_ok`→`addr_ok`, 0 cycles `mem_data_ok`→`data_ok`. All are combinational paths through registered selection state.
- **Throughput:** one accept per cycle; one return per cycle. Both may occur together.
- **Lock effect:** a new tie arriving while `lock` ≠ NONE is not evaluated until the cycle after the locked request is accepted.

## Test plan
- **Single inst read:**
  - Stimulus: `inst_req`=1, addr 0x0, slave addr_ok in cycle 0, data_ok in cycle 2 with rdata 0x3c010001.
  - Required: `inst_addr_ok` in cycle 0, `inst_data_ok` in cycle 2, `inst_rdata`=0x3c010001, all `data_*` strobes 0.
- **Simultaneous requests after reset:**
  - Stimulus: both masters request; slave always addr_ok; data is a write to 0x10 of 0xdeadbeef, size 2.
  - Required: data accepted first with `mem_wr`=1, `mem_addr`=0x10; inst accepted next cycle. Continuous ties alternate D,I,D,I.
- **Lock on stall:**
  - Stimulus: inst alone requests 0x4; slave withholds addr_ok 3 cycles; data raises req in cycle 1.
  - Required: `mem_addr` stays 0x4 until accept; data accepted in the following cycle.
- **Full FIFO (`DEPTH`=4):**
  - Stimulus: 4 accepted inst reads with no data_ok.
  - Required: `mem_req`=0 with `inst_req` held.
  - Follow-up: one `mem_data_ok`. Required: `inst_data_ok`, then `mem_req`=1 on the next cycle.
- **Interleaved routing:**
  - Stimulus: accept order I,D,D,I; returns rdata 1,2,3,4.
  - Required: inst gets 1 and 4, data gets 2 and 3.
- **Reset mid-flight:**
  - Stimulus: 2 outstanding requests, `rst`=0 for 1 cycle, then stray `mem_data_ok`.
  - Required: no `data_ok` on either master; `count`=0.
